// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
// The scheduler FSM states, forwarding-select encodings and the $0 register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULBUSY = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand.
// The youngest producer (EX/MEM) wins over MEM/WB; register $0 is never forwarded.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_regwrite_i,
  output logic [1:0]        fwd_o
);

  // Pick the most recent in-flight writer of src_i, falling back to the register file
  always_comb begin
    fwd_o = FWD_RF;
    if (exmem_regwrite_i && (exmem_rd_i != REG_AW'(REG_ZERO)) && (exmem_rd_i == src_i)) begin
      fwd_o = FWD_EXMEM;
    end else if (memwb_regwrite_i && (memwb_rd_i != REG_AW'(REG_ZERO)) && (memwb_rd_i == src_i)) begin
      fwd_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS pipeline: stalls, bubbles, flushes,
// EX forwarding selects and a saturating stall/flush cycle counter.
// Optional multi-cycle MUL stall is enabled by defining PIPE_MUL_STALL_EN.
// Control outputs are combinational from the registered state and current inputs.
module pipeline_hazard_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_jump_i,
  input  logic [REG_AW-1:0] idex_rs_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic              idex_memread_i,
  input  logic              idex_mul_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_regwrite_i,
  input  logic              exmem_taken_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_regwrite_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              exmem_flush_o,
  output logic              exmem_hold_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               load_use;
  logic               stall_evt;
  logic [1:0]         fwd_a, fwd_b;

`ifdef PIPE_MUL_STALL_EN
  localparam int MC_W = $clog2(MUL_CYCLES) + 1;
  logic [MC_W-1:0]    mul_cnt_q, mul_cnt_d;
`else
  logic               unused_mul;
  assign unused_mul = idex_mul_i;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i            (idex_rs_i),
    .exmem_rd_i       (exmem_rd_i),
    .exmem_regwrite_i (exmem_regwrite_i),
    .memwb_rd_i       (memwb_rd_i),
    .memwb_regwrite_i (memwb_regwrite_i),
    .fwd_o            (fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i            (idex_rt_i),
    .exmem_rd_i       (exmem_rd_i),
    .exmem_regwrite_i (exmem_regwrite_i),
    .memwb_rd_i       (memwb_rd_i),
    .memwb_regwrite_i (memwb_regwrite_i),
    .fwd_o            (fwd_b)
  );

  assign fwd_a_o = rst_i ? FWD_RF : fwd_a;
  assign fwd_b_o = rst_i ? FWD_RF : fwd_b;

  // A load in EX whose destination is read by the instruction in ID; $0 is never a hazard
  assign load_use = idex_memread_i && (idex_rt_i != REG_AW'(REG_ZERO)) &&
                    ((id_use_rs_i && (idex_rt_i == ifid_rs_i)) ||
                     (id_use_rt_i && (idex_rt_i == ifid_rt_i)));

  // Next-state and control decode; priority taken > MUL busy > load-use > jump
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    exmem_hold_o  = 1'b0;
    state_d       = state_q;
`ifdef PIPE_MUL_STALL_EN
    mul_cnt_d     = mul_cnt_q;
`endif
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      state_d       = RUN;
`ifdef PIPE_MUL_STALL_EN
      mul_cnt_d     = '0;
`endif
    end else if (exmem_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      state_d       = FLUSH;
`ifdef PIPE_MUL_STALL_EN
      mul_cnt_d     = '0;
`endif
    end else begin
      case (state_q)
        FLUSH: begin
          state_d = RUN;
        end
        MULBUSY: begin
`ifdef PIPE_MUL_STALL_EN
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          exmem_hold_o  = 1'b1;
          exmem_flush_o = 1'b1;
          mul_cnt_d     = mul_cnt_q - 1'b1;
          if (mul_cnt_q == MC_W'(1)) begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
        default: begin
`ifdef PIPE_MUL_STALL_EN
          if (idex_mul_i) begin
            state_d   = MULBUSY;
            mul_cnt_d = MC_W'(MUL_CYCLES - 1);
          end
`endif
          if (load_use) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
          end else if (id_jump_i) begin
            ifid_flush_o = 1'b1;
          end
        end
      endcase
    end
  end

  assign stall_evt   = !pc_write_o || ifid_flush_o || idex_flush_o || exmem_flush_o;
  assign stall_cnt_d = stall_evt ? sat_inc(stall_cnt_q) : stall_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  // State, MUL occupancy and stall counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
`ifdef PIPE_MUL_STALL_EN
      mul_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_MUL_STALL_EN
      mul_cnt_q   <= mul_cnt_d;
`endif
    end
  end

endmodule
